// File: rtl/mining_pkg.sv
// Shared definitions for the mining job sequencer: default nonce width, FSM state encoding, nonce type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mining_pkg;

    localparam int NONCE_W_DEFAULT = 32;

    // Sweep controller states; encoding is fixed so status readback tools can decode it.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    typedef logic [NONCE_W_DEFAULT-1:0] nonce_t;

endpackage

// File: rtl/nonce_sweep_ctrl_range_counter.sv
// Running nonce register for one sweep: load first/last, advance by STEP, flag the final attempt.
// Latency: load/advance take effect on the next clock; range_empty and at_end are combinational.
// Backpressure: none; the controller decides when to load or advance.
module nonce_range_counter #(
    parameter int          NONCE_W = 32,
    parameter int unsigned STEP    = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic               advance,
    input  logic [NONCE_W-1:0] first,
    input  logic [NONCE_W-1:0] last,
    output logic [NONCE_W-1:0] cur,
    output logic               range_empty,
    output logic               at_end
);

    localparam logic [NONCE_W:0] STEP_EXT = (NONCE_W+1)'(STEP);

    logic [NONCE_W-1:0] last_q;
    logic [NONCE_W:0]   next_ext;

    // One extra bit catches the carry out of cur+STEP so the sweep never wraps.
    assign next_ext = {1'b0, cur} + STEP_EXT;

    // Current attempt is the last one if it equals last, the next nonce passes last, or the add carries.
    always_comb begin
        at_end = (cur == last_q) || next_ext[NONCE_W] || (next_ext[NONCE_W-1:0] > last_q);
    end

    // A range whose start lies above its end (unsigned) has nothing to hash.
    always_comb begin
        range_empty = (first > last);
    end

    // Counter and latched range bound.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur    <= '0;
            last_q <= '0;
        end else if (load) begin
            cur    <= first;
            last_q <= last;
        end else if (advance) begin
            cur    <= next_ext[NONCE_W-1:0];
        end
    end

endmodule

// File: rtl/nonce_sweep_ctrl.sv
// Nonce sweep sequencer: walks [first,last] by STEP, one hash per nonce, ends on first hit or range end.
// Latency: accepted start -> first sha_start 1 cycle; sha_done -> next sha_start 1 cycle; done 1 cycle after end.
// Backpressure: one hash outstanding; waits on sha_done. NONCE_SWEEP_STATS_EN adds the attempts counter.
module nonce_sweep_ctrl
    import mining_pkg::*;
#(
    parameter int          NONCE_W = NONCE_W_DEFAULT,
    parameter int unsigned STEP    = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               stop,
    input  logic [NONCE_W-1:0] nonce_first,
    input  logic [NONCE_W-1:0] nonce_last,
    output logic               sha_start,
    output logic [NONCE_W-1:0] sha_nonce,
    input  logic               sha_done,
    input  logic               sha_hit,
    output logic               busy,
    output logic               found,
    output logic [NONCE_W-1:0] found_nonce,
    output logic               exhausted,
    output logic               done
`ifdef NONCE_SWEEP_STATS_EN
    ,
    output logic [NONCE_W:0]   attempts
`endif
);

    state_t             state;
    state_t             state_nxt;
    logic               load;
    logic               advance;
    logic               set_found;
    logic               set_exh;
    logic               clr_status;
    logic [NONCE_W-1:0] cur;
    logic               range_empty;
    logic               at_end;

    nonce_range_counter #(
        .NONCE_W (NONCE_W),
        .STEP    (STEP)
    ) u_range (
        .clk         (clk),
        .reset_n     (reset_n),
        .load        (load),
        .advance     (advance),
        .first       (nonce_first),
        .last        (nonce_last),
        .cur         (cur),
        .range_empty (range_empty),
        .at_end      (at_end)
    );

    assign sha_nonce = cur;
    assign busy      = (state != IDLE);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-cycle controls; stop always takes priority over a completing hash.
    always_comb begin
        state_nxt  = state;
        sha_start  = 1'b0;
        load       = 1'b0;
        advance    = 1'b0;
        set_found  = 1'b0;
        set_exh    = 1'b0;
        clr_status = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    clr_status = 1'b1;
                    if (range_empty) begin
                        set_exh = 1'b1;
                    end else begin
                        state_nxt = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else begin
                    sha_start = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (stop) begin
                    // The core is still busy unless it finishes this very cycle.
                    state_nxt = sha_done ? IDLE : DRAIN;
                end else if (sha_done) begin
                    if (sha_hit) begin
                        set_found = 1'b1;
                        state_nxt = IDLE;
                    end else if (at_end) begin
                        set_exh   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        advance   = 1'b1;
                        state_nxt = ISSUE;
                    end
                end
            end
            DRAIN: begin
                if (sha_done) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Sticky result flags and the one-cycle completion pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            found       <= 1'b0;
            found_nonce <= '0;
            exhausted   <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= set_found | set_exh;
            if (clr_status) begin
                found       <= 1'b0;
                found_nonce <= '0;
                exhausted   <= 1'b0;
            end
            if (set_found) begin
                found       <= 1'b1;
                found_nonce <= cur;
            end
            if (set_exh) begin
                exhausted   <= 1'b1;
            end
        end
    end

`ifdef NONCE_SWEEP_STATS_EN
    logic accept_done;

    // Only results consumed in WAIT count; drained or aborted attempts are discarded.
    assign accept_done = (state == WAIT) && sha_done && !stop;

    // Saturating count of completed attempts in the current sweep.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            attempts <= '0;
        end else if (load) begin
            attempts <= '0;
        end else if (accept_done && (attempts != '1)) begin
            attempts <= attempts + 1'b1;
        end
    end
`endif

endmodule

// File: doc/nonce_sweep_ctrl.md
Name: nonce_sweep_ctrl

Overview:
Sequences a nonce sweep for one mining job: walks a nonce range, issues each nonce to the SHA-256 double-hash core over a start/done handshake, and stops on the first target hit or at end of range.
Sits between the job/config registers (host side) and the hash datapath. Owns the running nonce counter.
Reports the found nonce or range exhaustion as sticky status.

Parameters:
NONCE_W, 32, nonce width in bits
STEP, 1, nonce increment per attempt (1..2^NONCE_W-1; >1 lets parallel instances interleave ranges)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begin sweep (ignored unless IDLE)
stop  input  1  abort request (level or pulse, sampled every cycle)
nonce_first  input  NONCE_W  first nonce of range, latched on accepted start
nonce_last  input  NONCE_W  last nonce of range (inclusive), latched on accepted start
sha_start  output  1  one-cycle pulse to hash core
sha_nonce  output  NONCE_W  nonce under hash; stable from sha_start until sha_done
sha_done  input  1  one-cycle pulse from hash core, result valid
sha_hit  input  1  hash <= target; qualified by sha_done
busy  output  1  high in any state except IDLE
found  output  1  sticky; hit occurred in last sweep
found_nonce  output  NONCE_W  nonce that hit; valid while found
exhausted  output  1  sticky; range finished with no hit
done  output  1  one-cycle pulse when sweep ends by hit or exhaustion (not on abort)

Behaviour:
- Reset (async assert, sync deassert assumed upstream): state IDLE; all outputs 0; cur nonce 0; latched range 0.
- States: IDLE, ISSUE, WAIT, DRAIN.
- IDLE: start=1 -> latch nonce_first/nonce_last, cur<=nonce_first, clear found/exhausted.
  - If nonce_first > nonce_last (unsigned): exhausted<=1, done pulse next cycle, remain IDLE, no hash issued.
  - Else -> ISSUE.
- ISSUE: sha_start=1 for exactly this cycle, sha_nonce=cur -> WAIT. Latency start->first sha_start = 1 cycle.
- WAIT: hold sha_nonce. On sha_done:
  - sha_hit=1 -> found<=1, found_nonce<=cur, done pulse, -> IDLE.
  - else if cur==nonce_last, or cur+STEP > nonce_last, or cur+STEP carries out of NONCE_W -> exhausted<=1, done pulse, -> IDLE.
  - else cur<=cur+STEP -> ISSUE.
  - Back-to-back attempt: sha_done cycle + 1 cycle = next sha_start.
- Wrap-around: never wraps; carry out of cur+STEP always ends sweep (range 0xFFFFFFFF..0xFFFFFFFF issues once).
- stop: in ISSUE -> IDLE (no sha_start issued that cycle). In WAIT -> DRAIN. In DRAIN: wait for sha_done, discard result, -> IDLE. In IDLE: no effect.
- stop and sha_done in same WAIT cycle: stop wins, result discarded, -> IDLE directly.
- Abort leaves found=exhausted=0, done not pulsed.
- start while busy ignored; sha_done outside WAIT/DRAIN ignored.
- reset_n mid-sweep: immediate return to reset values; hash core is reset on the same net.

Optional Feature:
NONCE_SWEEP_STATS_EN
- Defined: extra output attempts[NONCE_W:0]; cleared on accepted start; +1 on every sha_done accepted in WAIT (hit or miss). Saturates at all-ones. Aborted/drained attempts not counted.
- Undefined: port and counter absent; no other behavioural change.

Decomposition:
- Shared package mining_pkg: NONCE_W default, state encoding constants (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, DRAIN=2'd3), nonce type.
- One natural sub-module: nonce_range_counter (load, step, last-compare, end flag). The FSM stays in the top.

Test Plan:
- first=0x10, last=0x13, sha_hit never -> sha_nonce 0x10,0x11,0x12,0x13 issued; exhausted=1, one done pulse, found=0.
- first=0x100, last=0x1FF, sha_hit on nonce 0x105 -> 6 sha_start pulses; found=1, found_nonce=0x105, done once; busy low next cycle.
- first=0xFFFFFFFE, last=0xFFFFFFFF, STEP=1 -> two attempts, no wrap to 0, exhausted=1. first=5,last=4 -> no sha_start, exhausted=1.
- stop asserted during WAIT of nonce 0x20 -> DRAIN until sha_done (sha_hit=1 ignored), IDLE, found=0, no done; new start then works.
- start pulsed while busy and spurious sha_done in IDLE -> no effect. reset_n low mid-WAIT -> all outputs 0 immediately.
- STEP=4, first=0, last=10 -> nonces 0,4,8 then exhausted; with NONCE_SWEEP_STATS_EN attempts=3.
